// File: rtl/bldc_commutator_pkg.sv
// Shared types and lookup tables for the BLDC six-step commutator.
// Tables are packed with sector/code 0 in the least significant slot.
package bldc_commutator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEAD,
        ST_DRIVE,
        ST_FAULT
    } state_t;

    typedef logic [2:0] sector_t;

    localparam logic [2:0] PH_A = 3'b001;
    localparam logic [2:0] PH_B = 3'b010;
    localparam logic [2:0] PH_C = 3'b100;

    // Per hall code {valid, sector}: 001->5 010->3 011->4 100->1 101->0 110->2
    localparam logic [31:0] HALL_TBL = 32'h0A89_CBD0;

    localparam logic [17:0] FWD_HI_TBL = {PH_C, PH_C, PH_B, PH_B, PH_A, PH_A};
    localparam logic [17:0] FWD_LO_TBL = {PH_B, PH_A, PH_A, PH_C, PH_C, PH_B};

    function automatic logic hall_valid(logic [2:0] code);
        return HALL_TBL[{code, 2'b11}];
    endfunction

    function automatic sector_t hall_sector(logic [2:0] code);
        return HALL_TBL[{code, 2'b00} +: 3];
    endfunction

    function automatic logic [2:0] fwd_hi(sector_t s);
        logic [4:0] b;
        b = 5'(s) * 5'd3;
        return FWD_HI_TBL[b +: 3];
    endfunction

    function automatic logic [2:0] fwd_lo(sector_t s);
        logic [4:0] b;
        b = 5'(s) * 5'd3;
        return FWD_LO_TBL[b +: 3];
    endfunction

    function automatic logic sector_adjacent(sector_t a, sector_t b);
        sector_t up;
        sector_t dn;
        up = (a == 3'd5) ? 3'd0 : a + 3'd1;
        dn = (a == 3'd0) ? 3'd5 : a - 3'd1;
        return (b == up) || (b == dn);
    endfunction

endpackage

// File: rtl/bldc_commutator_hall_debounce.sv
// Hall input synchronizer and stability filter; strobe marks each
// acceptance of a code that held steady for DEBOUNCE_CYC cycles.
module hall_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] hall,
    output logic [2:0] code,
    output logic       locked,
    output logic       strobe
);

    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYC - 1);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] sync3;
    logic [2:0] warm;
    logic [7:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1  <= '0;
            sync2  <= '0;
            sync3  <= '0;
            warm   <= '0;
            cnt    <= '0;
            code   <= '0;
            locked <= 1'b0;
            strobe <= 1'b0;
        end else begin
            sync1  <= hall;
            sync2  <= sync1;
            sync3  <= sync2;
            warm   <= {warm[1:0], 1'b1};
            strobe <= 1'b0;
            // Hold off until the synchronizer carries real samples
            if (!warm[2] || sync2 != sync3) begin
                cnt <= '0;
            end else if (cnt < LAST) begin
                cnt <= cnt + 8'd1;
            end else if (cnt == LAST) begin
                cnt    <= cnt + 8'd1;
                code   <= sync2;
                locked <= 1'b1;
                strobe <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator with hall debounce and dead-time insertion.
// Define HALL_SEQ_CHECK_EN to fault on non-adjacent sector jumps.
module bldc_commutator
    import bldc_commutator_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 16,
    parameter int unsigned DEAD_CYC     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] hall,
    input  logic       enable,
    input  logic       dir,
    input  logic       pwm_in,
    output logic [2:0] gate_hi,
    output logic [2:0] gate_lo,
    output logic [2:0] sector,
    output logic       step_pulse,
    output logic       fault
);

    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

    logic [2:0] acc_code;
    logic       acc_lock;
    logic       acc_stb;

    hall_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb (
        .CLK   (CLK),
        .RST   (RST),
        .hall  (hall),
        .code  (acc_code),
        .locked(acc_lock),
        .strobe(acc_stb)
    );

    state_t     state;
    logic [7:0] dead_cnt;
    logic       dir_q;
    sector_t    new_sec;
    logic       code_ok;
    logic       acc_valid;
    logic       acc_bad;
    logic       sec_chg;
    logic       seq_bad;
    logic [2:0] hi_pat;
    logic [2:0] lo_pat;

    assign code_ok   = acc_lock && hall_valid(acc_code);
    assign new_sec   = hall_sector(acc_code);
    assign acc_valid = acc_stb && hall_valid(acc_code);
    assign acc_bad   = acc_stb && !hall_valid(acc_code);
    assign sec_chg   = acc_valid && (new_sec != sector);

`ifdef HALL_SEQ_CHECK_EN
    assign seq_bad = sec_chg && !sector_adjacent(sector, new_sec);
`else
    assign seq_bad = 1'b0;
`endif

    // Reverse simply exchanges the high and low phase of each sector
    assign hi_pat = dir ? fwd_lo(sector) : fwd_hi(sector);
    assign lo_pat = dir ? fwd_hi(sector) : fwd_lo(sector);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            dead_cnt   <= '0;
            dir_q      <= 1'b0;
            sector     <= '0;
            step_pulse <= 1'b0;
            fault      <= 1'b0;
            gate_hi    <= '0;
            gate_lo    <= '0;
        end else begin
            step_pulse <= sec_chg;
            if (acc_valid)
                sector <= new_sec;
            gate_hi <= '0;
            gate_lo <= '0;
            unique case (state)
                ST_IDLE: begin
                    dead_cnt <= '0;
                    if (enable && code_ok)
                        state <= ST_DEAD;
                end
                ST_DEAD: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (acc_bad || seq_bad) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else if (sec_chg) begin
                        dead_cnt <= '0;
                    end else if (dead_cnt == DEAD_LAST) begin
                        state   <= ST_DRIVE;
                        dir_q   <= dir;
                        gate_hi <= hi_pat & {3{pwm_in}};
                        gate_lo <= lo_pat;
                    end else begin
                        dead_cnt <= dead_cnt + 8'd1;
                    end
                end
                ST_DRIVE: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (acc_bad || seq_bad) begin
                        state <= ST_FAULT;
                        fault <= 1'b1;
                    end else if (sec_chg || dir != dir_q) begin
                        state    <= ST_DEAD;
                        dead_cnt <= '0;
                    end else begin
                        gate_hi <= hi_pat & {3{pwm_in}};
                        gate_lo <= lo_pat;
                    end
                end
                ST_FAULT: begin
                    if (!enable) begin
                        state <= ST_IDLE;
                        fault <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: expected output changes are queued
// by the stimulus and matched by a monitor against each observed change.
module tb_bldc_commutator;

    localparam int DEB  = 16;
    localparam int DEAD = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic [2:0] hall;
    logic       enable;
    logic       dir;
    logic       pwm_in;
    logic [2:0] gate_hi;
    logic [2:0] gate_lo;
    logic [2:0] sector;
    logic       step_pulse;
    logic       fault;

    bldc_commutator #(
        .DEBOUNCE_CYC(DEB),
        .DEAD_CYC    (DEAD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .hall      (hall),
        .enable    (enable),
        .dir       (dir),
        .pwm_in    (pwm_in),
        .gate_hi   (gate_hi),
        .gate_lo   (gate_lo),
        .sector    (sector),
        .step_pulse(step_pulse),
        .fault     (fault)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2:0] hi;
        logic [2:0] lo;
        logic [2:0] sec;
        logic       flt;
        logic       rel;
        int         lo_c;
        int         hi_c;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    tests    = 0;
    int    fails    = 0;
    int    cyc      = 0;
    int    steps    = 0;
    int    overlaps = 0;
    bit    mon_on   = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin : monitor
        logic [9:0] prev;
        logic [9:0] cur;
        logic [9:0] want;
        int         last_ev;
        int         wlo;
        int         whi;
        exp_t       e;
        string      nm;
        wait (mon_on);
        @(negedge CLK);
        prev    = {gate_hi, gate_lo, sector, fault};
        last_ev = cyc;
        forever begin
            @(negedge CLK);
            cur = {gate_hi, gate_lo, sector, fault};
            if (step_pulse) steps++;
            if ((gate_hi & gate_lo) != 3'b000) overlaps++;
            if (cur != prev) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got hi=%b lo=%b sec=%0d flt=%b at cyc %0d, required no change",
                             gate_hi, gate_lo, sector, fault, cyc);
                end else begin
                    e    = q.pop_front();
                    nm   = nq.pop_front();
                    want = {e.hi, e.lo, e.sec, e.flt};
                    wlo  = e.rel ? last_ev + e.lo_c : e.lo_c;
                    whi  = e.rel ? last_ev + e.hi_c : e.hi_c;
                    if (cur != want || cyc < wlo || cyc > whi) begin
                        fails++;
                        $display("FAIL %s: got hi=%b lo=%b sec=%0d flt=%b at cyc %0d, required hi=%b lo=%b sec=%0d flt=%b in cyc [%0d,%0d]",
                                 nm, gate_hi, gate_lo, sector, fault, cyc,
                                 e.hi, e.lo, e.sec, e.flt, wlo, whi);
                    end
                end
                prev    = cur;
                last_ev = cyc;
            end
        end
    end

    task automatic expect_ev(input string nm, input logic [2:0] hi,
                             input logic [2:0] lo, input logic [2:0] sec,
                             input logic flt, input logic rel,
                             input int lo_c, input int hi_c);
        exp_t e;
        e.hi   = hi;
        e.lo   = lo;
        e.sec  = sec;
        e.flt  = flt;
        e.rel  = rel;
        e.lo_c = lo_c;
        e.hi_c = hi_c;
        q.push_back(e);
        nq.push_back(nm);
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got %0d pending events, required 0", nm, q.size());
            q.delete();
            nq.delete();
        end
    endtask

    task automatic check(input string nm, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", nm, got, want);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int c;
        RST    = 1'b0;
        hall   = 3'b100;
        enable = 1'b0;
        dir    = 1'b0;
        pwm_in = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_gate_hi", gate_hi, 0);
        check("rst_gate_lo", gate_lo, 0);
        check("rst_sector", sector, 0);
        check("rst_fault", fault, 0);
        check("rst_step", step_pulse, 0);

        // Boot with hall=100: sector 1 no earlier than DEB+2 cycles
        RST    = 1'b1;
        c      = cyc;
        mon_on = 1'b1;
        expect_ev("boot_s1", 3'b000, 3'b000, 3'd1, 1'b0, 1'b0, c + DEB + 2, c + DEB + 6);
        drain("boot", 60);
        check("steps_boot", steps, 1);

        @(negedge CLK);
        hall = 3'b101;
        c    = cyc;
        expect_ev("idle_s0", 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, c + DEB + 2, c + DEB + 6);
        drain("idle_s0", 60);
        check("steps_s0", steps, 2);

        @(negedge CLK);
        enable = 1'b1;
        c      = cyc;
        expect_ev("drive_s0", 3'b001, 3'b010, 3'd0, 1'b0, 1'b0, c + DEAD, c + DEAD + 2);
        drain("drive_s0", 40);

        @(negedge CLK);
        hall = 3'b100;
        c    = cyc;
        expect_ev("dead_s1", 3'b000, 3'b000, 3'd1, 1'b0, 1'b0, c + DEB + 2, c + DEB + 6);
        expect_ev("drive_s1", 3'b001, 3'b100, 3'd1, 1'b0, 1'b1, DEAD, DEAD);
        drain("step_s1", 80);
        check("steps_s1", steps, 3);

        @(negedge CLK);
        hall = 3'b101;
        repeat (5) @(negedge CLK);
        hall = 3'b100;
        repeat (DEB + 10) @(negedge CLK);
        check("glitch_hi", gate_hi, 3'b001);
        check("glitch_lo", gate_lo, 3'b100);
        check("glitch_sector", sector, 1);
        check("glitch_steps", steps, 3);

        @(negedge CLK);
        hall = 3'b111;
        c    = cyc;
        expect_ev("fault_set", 3'b000, 3'b000, 3'd1, 1'b1, 1'b0, c + DEB + 2, c + DEB + 6);
        drain("fault_set", 60);
        @(negedge CLK);
        enable = 1'b0;
        c      = cyc;
        expect_ev("fault_clr", 3'b000, 3'b000, 3'd1, 1'b0, 1'b0, c + 1, c + 2);
        drain("fault_clr", 20);
        check("steps_fault", steps, 3);

        @(negedge CLK);
        hall = 3'b110;
        c    = cyc;
        expect_ev("idle_s2", 3'b000, 3'b000, 3'd2, 1'b0, 1'b0, c + DEB + 2, c + DEB + 6);
        drain("idle_s2", 60);
        check("steps_s2", steps, 4);
        @(negedge CLK);
        enable = 1'b1;
        c      = cyc;
        expect_ev("drive_s2", 3'b010, 3'b100, 3'd2, 1'b0, 1'b0, c + DEAD, c + DEAD + 2);
        drain("drive_s2", 40);

        @(negedge CLK);
        dir = 1'b1;
        c   = cyc;
        expect_ev("dir_dead", 3'b000, 3'b000, 3'd2, 1'b0, 1'b0, c + 1, c + 2);
        expect_ev("drive_s2_rev", 3'b100, 3'b010, 3'd2, 1'b0, 1'b1, DEAD, DEAD);
        drain("dir_rev", 40);

        @(negedge CLK);
        pwm_in = 1'b0;
        c      = cyc;
        expect_ev("pwm_off", 3'b000, 3'b010, 3'd2, 1'b0, 1'b0, c + 1, c + 2);
        drain("pwm_off", 20);
        @(negedge CLK);
        pwm_in = 1'b1;
        c      = cyc;
        expect_ev("pwm_on", 3'b100, 3'b010, 3'd2, 1'b0, 1'b0, c + 1, c + 2);
        drain("pwm_on", 20);

        // Three-sector jump s2 -> s5
        @(negedge CLK);
        hall = 3'b001;
        c    = cyc;
`ifdef HALL_SEQ_CHECK_EN
        expect_ev("seq_fault", 3'b000, 3'b000, 3'd5, 1'b1, 1'b0, c + DEB + 2, c + DEB + 6);
`else
        expect_ev("jump_s5", 3'b000, 3'b000, 3'd5, 1'b0, 1'b0, c + DEB + 2, c + DEB + 6);
        expect_ev("drive_s5_rev", 3'b010, 3'b100, 3'd5, 1'b0, 1'b1, DEAD, DEAD);
`endif
        drain("jump", 80);
        check("steps_jump", steps, 5);

        @(negedge CLK);
        #2;
        c = cyc;
        expect_ev("async_rst", 3'b000, 3'b000, 3'd0, 1'b0, 1'b0, c, c + 1);
        RST = 1'b0;
        #1;
        check("async_rst_hi", gate_hi, 0);
        check("async_rst_lo", gate_lo, 0);
        drain("async_rst", 5);

        check("gate_overlap", overlaps, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
